uart_mmio_initiator: RTL
========================

# uart_mmio_initiator

Bus-side initiator that drives the memory-mapped UART peripheral from the core. It accepts single-byte transmit and receive requests, then polls the peripheral status register until the UART is ready. It issues the debounced read or write strobe with the required hold and release times and returns the received byte with a completion pulse. It sits between the ARC control unit's I/O request path and the peripheral block's `wr`/`rd`/`s_io`/`s_mmio`/`data_in`/`data_out` pins.

## Interface
- `HOLD_CYC`, 1100000 — cycles each strobe is held high, and then held low, so the peripheral debouncer registers exactly one tick; minimum 1.
- `CW`, 21 — hold counter width; must satisfy `2**CW > HOLD_CYC`.
- `POLL_LIMIT`, 1024 — maximum status polls before abort (only with `UART_MMIO_TIMEOUT_EN`).
- `clk` in 1 — single system clock.
- `rst` in 1 — reset. Synchronous, active-low.
- `req_wr` in 1 — request to transmit `wr_byte`; sampled in IDLE only.
- `req_rd` in 1 — request to receive one byte; sampled in IDLE only.
- `wr_byte` in 8 — byte to transmit.
- `busy` out 1 — high from the accept cycle through the DONE cycle.
- `done` out 1 — one-cycle completion pulse.
- `err` out 1 — valid with `done`; 1 = poll timeout, no strobe issued.
- `rd_byte` out 8 — received byte; updated only on a successful read.
- `per_wr`, `per_rd` out 1 — strobes to the peripheral.
- `per_s_io` out 1 — 0 selects the status register, 1 selects the UART data register.
- `per_s_mmio` out 1 — peripheral select; asserted only together with a strobe.
- `per_data_out` out 8 — to peripheral `data_in`.
- `per_data_in` in 8 — from peripheral `data_out`; status bit1 = tx_full, bit0 = rx_empty.

## Operation
- States: IDLE, STAT_SEL, STAT_CHK, RD_SEL, RD_CAP, STB, REL, DONE.
- IDLE:
  - If `req_wr` is high, latch `wr_byte` into `per_data_out` and mark op = write.
  - Otherwise, if `req_rd` is high, mark op = read.
  - If both are high, write wins and the read is dropped.
  - After accepting either request, go to STAT_SEL.
- STAT_SEL: drive `per_s_io`=0 for one cycle. Go to STAT_CHK.
- STAT_CHK: sample `per_data_in`.
  - Ready means write with bit1=0, or read with bit0=0.
  - Ready and write: go to STB.
  - Ready and read: go to RD_SEL.
  - Not ready: increment the poll count and go to STAT_SEL.
- RD_SEL: drive `per_s_io`=1 for one cycle. Go to RD_CAP.
- RD_CAP: latch `per_data_in` into `rd_byte` before the FIFO pop. Go to STB.
- STB:
  - Assert `per_s_mmio`=1 plus `per_wr` or `per_rd` (per op) for exactly `HOLD_CYC` cycles.
  - `per_data_out` stays stable throughout.
  - Go to REL.
- REL: hold all strobes and `per_s_mmio` low for `HOLD_CYC` cycles. Go to DONE.
- DONE: `done`=1 for one cycle. Go to IDLE.
- Requests are ignored while `busy`=1; there is no queueing.
- Reset values: state IDLE; `busy`, `done`, `err`, `per_wr`, `per_rd`, `per_s_mmio`, `per_s_io` = 0; `rd_byte` and `per_data_out` = 8'h00; counters cleared.
- Reset mid-STB drops the strobe on the next edge with no `done`. The peripheral may or may not see a tick; callers must re-check status.

## Timing
- All outputs are registered.
- Write, ready on first poll: accept at cycle 0, STAT_SEL 1, STAT_CHK 2, STB 3..2+H, REL 3+H..2+2H, `done` at 3+2H (H = `HOLD_CYC`).
- Read, ready on first poll: 2 cycles longer than write; `done` at 5+2H, with `rd_byte` valid from cycle 5.
- Each failed poll adds 2 cycles.
- `per_s_mmio` is never high outside STB.
- `per_wr` and `per_rd` are never high together.

## Configuration
- `UART_MMIO_TIMEOUT_EN` defined:
  - When the poll count reaches `POLL_LIMIT` failed polls, go directly to DONE with `err`=1.
  - No strobe is issued and `rd_byte` is unchanged.
- `UART_MMIO_TIMEOUT_EN` undefined:
  - Polling continues indefinitely.
  - `err` is tied to 0 and the poll counter is not instantiated.

## Structure
- Package `uart_mmio_pkg` holds:
  - the state encoding;
  - status bit indices `STAT_TXFULL`=1 and `STAT_RXEMPTY`=0;
  - op codes `OP_WR` and `OP_RD`.
- Sub-module `hold_timer` is a loadable `CW`-bit down counter with `load`, `zero` outputs. It is shared by STB and REL.

## Test plan
- With `HOLD_CYC`=4, `req_wr` and `wr_byte`=8'hA5, status 8'h00 → `per_wr`=1 with `per_s_mmio`=1 on cycles 3–6, `per_data_out`=8'hA5, `done` at cycle 11.
- With status 8'h02 for 3 polls then 8'h00 → 3 extra STAT_SEL/STAT_CHK rounds, no strobe until ready, `done` 6 cycles later than baseline.
- `req_rd`, status 8'h00, data 8'h3C → `rd_byte`=8'h3C at cycle 5, `per_rd` on cycles 5–8, `done` at cycle 13.
- `req_wr` and `req_rd` in the same cycle → only the write executes; a `req_rd` pulse while `busy` is ignored.
- `rst`=0 during cycle 4 of STB → all strobes 0 on the next edge, `busy`=0, no `done`.
- With `UART_MMIO_TIMEOUT_EN`, `POLL_LIMIT`=8, status held at 8'h01 for a read → `done` with `err`=1 after 8 polls, `per_rd` never asserted.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared encodings for the UART MMIO initiator: FSM states, status bit
// positions, op codes and the status-ready decode.
package uart_mmio_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STAT_SEL = 3'd1;
  localparam logic [2:0] S_STAT_CHK = 3'd2;
  localparam logic [2:0] S_RD_SEL   = 3'd3;
  localparam logic [2:0] S_RD_CAP   = 3'd4;
  localparam logic [2:0] S_STB      = 3'd5;
  localparam logic [2:0] S_REL      = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam int STAT_TXFULL  = 1;
  localparam int STAT_RXEMPTY = 0;

  typedef logic op_t;
  localparam op_t OP_WR = 1'b1;
  localparam op_t OP_RD = 1'b0;

  // A write needs TX space, a read needs RX data; the other status bit is ignored.
  function automatic logic stat_ready(input op_t op, input logic [7:0] stat);
    return (op == OP_WR) ? !stat[STAT_TXFULL] : !stat[STAT_RXEMPTY];
  endfunction

endpackage

// File: rtl/uart_mmio_initiator_hold_timer.sv
// Loadable down counter timing the strobe hold and release phases.
module hold_timer #(
  parameter int CW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/uart_mmio_initiator.sv
// Single-byte initiator for the memory-mapped UART: polls status, then issues a
// debounced wr/rd strobe. Optional poll timeout enabled by UART_MMIO_TIMEOUT_EN.
module uart_mmio_initiator
  import uart_mmio_pkg::*;
#(
  parameter int HOLD_CYC   = 1100000,
  parameter int CW         = 21,
  parameter int POLL_LIMIT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] wr_byte,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rd_byte,
  output logic       per_wr,
  output logic       per_rd,
  output logic       per_s_io,
  output logic       per_s_mmio,
  output logic [7:0] per_data_out,
  input  logic [7:0] per_data_in
);

  if (HOLD_CYC < 1 || POLL_LIMIT < 1 || (HOLD_CYC >> CW) != 0) begin : g_bad_cfg
    $error("uart_mmio_initiator: need HOLD_CYC >= 1, POLL_LIMIT >= 1, 2**CW > HOLD_CYC");
  end

  logic [2:0] state, next_state;
  op_t        op;
  logic       poll_ready, timeout;
  logic       tmr_load, tmr_zero;

  assign poll_ready = stat_ready(op, per_data_in);

  hold_timer #(.CW(CW)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CW'(HOLD_CYC - 1)),
    .zero     (tmr_zero)
  );

`ifdef UART_MMIO_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;

  always_ff @(posedge clk) begin
    if (!rst || state == S_IDLE)
      poll_cnt <= '0;
    else if (state == S_STAT_CHK && !poll_ready)
      poll_cnt <= poll_cnt + PW'(1);
  end

  // Abort on the POLL_LIMIT-th failed poll, before any strobe.
  assign timeout = (state == S_STAT_CHK) && !poll_ready && (poll_cnt == PW'(POLL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst)
      err <= 1'b0;
    else
      err <= (next_state == S_DONE) && timeout;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (req_wr || req_rd) next_state = S_STAT_SEL;
      S_STAT_SEL: next_state = S_STAT_CHK;
      S_STAT_CHK: begin
        if (poll_ready)
          next_state = (op == OP_WR) ? S_STB : S_RD_SEL;
        else if (timeout)
          next_state = S_DONE;
        else
          next_state = S_STAT_SEL;
      end
      S_RD_SEL:   next_state = S_RD_CAP;
      S_RD_CAP:   next_state = S_STB;
      S_STB:      if (tmr_zero) next_state = S_REL;
      S_REL:      if (tmr_zero) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  assign tmr_load = (next_state != state) && (next_state == S_STB || next_state == S_REL);

  // Outputs are registered from next_state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      op           <= OP_RD;
      busy         <= 1'b0;
      done         <= 1'b0;
      per_wr       <= 1'b0;
      per_rd       <= 1'b0;
      per_s_mmio   <= 1'b0;
      per_s_io     <= 1'b0;
      rd_byte      <= 8'h00;
      per_data_out <= 8'h00;
    end else begin
      state      <= next_state;
      busy       <= (next_state != S_IDLE);
      done       <= (next_state == S_DONE);
      per_wr     <= (next_state == S_STB) && (op == OP_WR);
      per_rd     <= (next_state == S_STB) && (op == OP_RD);
      per_s_mmio <= (next_state == S_STB);
      per_s_io   <= (next_state == S_RD_SEL) || (next_state == S_RD_CAP) ||
                    (next_state == S_STB)    || (next_state == S_REL);
      if (state == S_IDLE) begin
        if (req_wr) begin
          op           <= OP_WR;
          per_data_out <= wr_byte;
        end else if (req_rd) begin
          op           <= OP_RD;
        end
      end
      // Capture the FIFO head before the read strobe pops it.
      if (state == S_RD_CAP)
        rd_byte <= per_data_in;
    end
  end

endmodule
